xbar_rr_switch: RTL

Registered, parametrised N_IN x N_OUT crossbar switch with valid/ready handshakes on every port. Each output port has its own round-robin arbiter and a one-entry output register. Per-output enable and sticky error reporting replace the combinational select/encode path of the first-generation crossbar. The switch sits between producer and consumer channels of the crossbar datapath, in the same place the combinational crossbar sat.

---
 rtl/xbar_rr_switch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/xbar_rr_switch.sv
// Purpose: registered N_IN x N_OUT crossbar with a round-robin arbiter and one-entry register per output.
// Latency: 1 cycle from input acceptance to OUT_VALID/OUT_DATA.
// Backpressure: IN_READY is a combinational grant; a full output slot stalls while OUT_READY=0 or OUT_EN=0.
module xbar_rr_switch #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int W      = 8,
    parameter int DEST_W = 2,
    parameter int SRC_W  = 2
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic [N_IN*W-1:0]       IN_DATA,
    input  logic [N_IN*DEST_W-1:0]  IN_DEST,
    input  logic [N_IN-1:0]         IN_VALID,
    output logic [N_IN-1:0]         IN_READY,
    input  logic [N_OUT-1:0]        OUT_EN,
    output logic [N_OUT*W-1:0]      OUT_DATA,
    output logic [N_OUT*SRC_W-1:0]  OUT_SRC,
    output logic [N_OUT-1:0]        OUT_VALID,
    input  logic [N_OUT-1:0]        OUT_READY,
    output logic                    ERR,
    input  logic                    ERR_CLR
);

    // Output slot state
    logic [N_OUT-1:0]       vld_q;
    logic [N_OUT*W-1:0]     dat_q;
    logic [N_OUT*SRC_W-1:0] src_q;
    logic                   err_q;

    // Round-robin pointer per output: first input index to examine
    logic [SRC_W-1:0]       ptr [N_OUT];
    logic [SRC_W-1:0]       ptr_nxt [N_OUT];

    // Arbitration results
    logic [N_OUT-1:0]       can_take;
    logic [N_IN-1:0]        illegal;
    logic [N_IN-1:0]        gnt [N_OUT];
    logic [N_OUT-1:0]       gnt_vld;
    logic [SRC_W-1:0]       gnt_src [N_OUT];
    logic [W-1:0]           gnt_dat [N_OUT];
    logic [N_IN-1:0]        gnt_any;

    // A slot accepts a new word when enabled and either empty or draining this cycle
    assign can_take = OUT_EN & (~vld_q | OUT_READY);

    // Flag inputs whose destination names a nonexistent output; they are swallowed immediately
    always_comb begin
        illegal = '0;
        for (int i = 0; i < N_IN; i++) begin
            illegal[i] = IN_VALID[i] & (int'(IN_DEST[i*DEST_W +: DEST_W]) >= N_OUT);
        end
    end

    // Per-output round-robin search starting at ptr, wrapping modulo N_IN
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int j = 0; j < N_OUT; j++) begin
            gnt[j]     = '0;
            gnt_vld[j] = 1'b0;
            gnt_src[j] = '0;
            gnt_dat[j] = '0;
            found      = 1'b0;
            if (can_take[j]) begin
                for (int off = 0; off < N_IN; off++) begin
                    idx = int'(ptr[j]) + off;
                    if (idx >= N_IN) begin
                        idx = idx - N_IN;
                    end
                    if (!found && IN_VALID[idx] &&
                        (int'(IN_DEST[idx*DEST_W +: DEST_W]) == j)) begin
                        found       = 1'b1;
                        gnt[j][idx] = 1'b1;
                        gnt_src[j]  = SRC_W'(idx);
                        gnt_dat[j]  = IN_DATA[idx*W +: W];
                    end
                end
            end
            gnt_vld[j] = found;
        end
    end

    // Next pointer is one past the granted input, wrapping at N_IN
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            if (int'(gnt_src[j]) == N_IN - 1) begin
                ptr_nxt[j] = '0;
            end else begin
                ptr_nxt[j] = gnt_src[j] + SRC_W'(1);
            end
        end
    end

    // Each input targets one output, so OR-ing the grant vectors yields at most one grant per input
    always_comb begin
        gnt_any = '0;
        for (int j = 0; j < N_OUT; j++) begin
            gnt_any = gnt_any | gnt[j];
        end
    end

    // Nothing is accepted while reset is held, so no word is half-taken across reset
    assign IN_READY = RSTN ? (gnt_any | illegal) : '0;

    // Load granted words into output slots, clear valid on drain without refill, advance pointers
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            vld_q <= '0;
            dat_q <= '0;
            src_q <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                ptr[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (gnt_vld[j]) begin
                    vld_q[j]                  <= 1'b1;
                    dat_q[j*W +: W]           <= gnt_dat[j];
                    src_q[j*SRC_W +: SRC_W]   <= gnt_src[j];
                    ptr[j]                    <= ptr_nxt[j];
                end else if (OUT_READY[j]) begin
                    vld_q[j]                  <= 1'b0;
                end
            end
        end
    end

    // Sticky error: an illegal word sets it, clear request loses against a simultaneous set
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            err_q <= 1'b0;
        end else if (|illegal) begin
            err_q <= 1'b1;
        end else if (ERR_CLR) begin
            err_q <= 1'b0;
        end
    end

    assign OUT_VALID = vld_q;
    assign OUT_DATA  = dat_q;
    assign OUT_SRC   = src_q;
    assign ERR       = err_q;

endmodule
